// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the layer sequencer: FSM encoding, default sizes, weight-address packing.
// Combinational only; no latency.
// No flow control.
package nn_seq_pkg;

    localparam int N_IN_DEF  = 16;
    localparam int N_OUT_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_BIAS  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Weight ROM is laid out neuron-major: {out_idx, in_idx}.
    function automatic int unsigned waddr_pack(input int unsigned out_idx,
                                               input int unsigned in_idx,
                                               input int unsigned in_w);
        return (out_idx << in_w) | in_idx;
    endfunction

endpackage

// File: rtl/nn_idx_cnt.sv
// Wrapping index counter with synchronous clear, enable and terminal-count flag.
// Count updates one cycle after en; tc is a decode of the current count.
// No backpressure; en is the only hold mechanism.
module nn_idx_cnt #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == W'(MAX));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/nn_layer_seq.sv
// Fully-connected layer sequencer: clear / accumulate / (bias, with NN_LAYER_SEQ_BIAS_EN) / write per neuron.
// start to acc_clr is one cycle; N_IN+2 cycles per neuron (N_IN+3 with bias), done one cycle after last write.
// stall freezes ACCUM (index held, acc_en low); start is ignored unless IDLE.
module nn_layer_seq
    import nn_seq_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int IN_W  = $clog2(N_IN),
    parameter int OUT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state,
    output logic                  acc_clr,
    output logic                  acc_en,
    output logic [IN_W-1:0]       in_idx,
    output logic [IN_W+OUT_W-1:0] w_addr,
    output logic [OUT_W-1:0]      out_idx,
`ifdef NN_LAYER_SEQ_BIAS_EN
    output logic                  bias_en,
`endif
    output logic                  out_wr
);

    state_t st;
    logic   in_tc;
    logic   out_tc;
    logic   in_clr;
    logic   in_step;
    logic   out_clr;
    logic   out_step;

    assign in_clr   = (st == S_IDLE);
    assign in_step  = (st == S_ACCUM) && !stall;
    // Clearing in DONE as well leaves out_idx at 0 for the whole IDLE period.
    assign out_clr  = (st == S_IDLE) || (st == S_DONE);
    assign out_step = (st == S_WRITE) && !out_tc;

    nn_idx_cnt #(.W(IN_W), .MAX(N_IN - 1)) u_in_cnt (
        .clk (clk),
        .rst (rst),
        .clr (in_clr),
        .en  (in_step),
        .cnt (in_idx),
        .tc  (in_tc)
    );

    nn_idx_cnt #(.W(OUT_W), .MAX(N_OUT - 1)) u_out_cnt (
        .clk (clk),
        .rst (rst),
        .clr (out_clr),
        .en  (out_step),
        .cnt (out_idx),
        .tc  (out_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= S_IDLE;
        end else begin
            case (st)
                S_IDLE:  if (start) st <= S_CLEAR;
                S_CLEAR: st <= S_ACCUM;
                S_ACCUM: begin
                    if (!stall && in_tc) begin
`ifdef NN_LAYER_SEQ_BIAS_EN
                        st <= S_BIAS;
`else
                        st <= S_WRITE;
`endif
                    end
                end
`ifdef NN_LAYER_SEQ_BIAS_EN
                S_BIAS:  st <= S_WRITE;
`endif
                S_WRITE: st <= out_tc ? S_DONE : S_CLEAR;
                S_DONE:  st <= S_IDLE;
                default: st <= S_IDLE;
            endcase
        end
    end

    assign state   = st;
    assign busy    = (st != S_IDLE);
    assign done    = (st == S_DONE);
    assign acc_clr = (st == S_CLEAR);
    assign acc_en  = in_step;
    assign out_wr  = (st == S_WRITE);
`ifdef NN_LAYER_SEQ_BIAS_EN
    assign bias_en = (st == S_BIAS);
`endif
    assign w_addr  = (IN_W + OUT_W)'(waddr_pack(32'(out_idx), 32'(in_idx), IN_W));

endmodule

// File: tb/tb_nn_layer_seq.sv
// Directed bench for nn_layer_seq with a cycle-stamped scoreboard of expected sequencer events.
module tb_nn_layer_seq;

    localparam int NI = 16;
    localparam int NO = 4;
`ifdef NN_LAYER_SEQ_BIAS_EN
    localparam int P  = NI + 3;
`else
    localparam int P  = NI + 2;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic       stall;
    logic       busy;
    logic       done;
    logic [2:0] state;
    logic       acc_clr;
    logic       acc_en;
    logic [3:0] in_idx;
    logic [5:0] w_addr;
    logic [1:0] out_idx;
    logic       out_wr;
`ifdef NN_LAYER_SEQ_BIAS_EN
    logic       bias_en;
`endif

    nn_layer_seq #(.N_IN(NI), .N_OUT(NO)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .state   (state),
        .acc_clr (acc_clr),
        .acc_en  (acc_en),
        .in_idx  (in_idx),
        .w_addr  (w_addr),
        .out_idx (out_idx),
`ifdef NN_LAYER_SEQ_BIAS_EN
        .bias_en (bias_en),
`endif
        .out_wr  (out_wr)
    );

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t q_clr[$];
    ev_t q_beat[$];
    ev_t q_wr[$];
    ev_t q_done[$];
    ev_t q_bias[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 0;
    ev_t me;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected events for one layer started in cycle s; stall of sl cycles begins at global beat sb (-1: none).
    task automatic push_layer(input int s, input int sb, input int sl);
        ev_t e;
        int  sh;
        int  b;
        for (int n = 0; n < NO; n++) begin
            sh = (sb >= 0 && sb < n * NI) ? sl : 0;
            e.cyc = s + 1 + n * P + sh;
            e.val = n;
            q_clr.push_back(e);
            for (int i = 0; i < NI; i++) begin
                b = n * NI + i;
                sh = (sb >= 0 && b >= sb) ? sl : 0;
                e.cyc = s + 2 + n * P + i + sh;
                e.val = b;
                q_beat.push_back(e);
            end
            sh = (sb >= 0 && sb < (n + 1) * NI) ? sl : 0;
`ifdef NN_LAYER_SEQ_BIAS_EN
            e.cyc = s + 2 + NI + n * P + sh;
            e.val = n;
            q_bias.push_back(e);
`endif
            e.cyc = s + (n + 1) * P + sh;
            e.val = n;
            q_wr.push_back(e);
        end
        e.cyc = s + NO * P + 1 + ((sb >= 0) ? sl : 0);
        e.val = 0;
        q_done.push_back(e);
    endtask

    // A reset in cycle c cancels everything scheduled after c.
    task automatic drop_after(input int c);
        while (q_clr.size() > 0 && q_clr[$].cyc > c) void'(q_clr.pop_back());
        while (q_beat.size() > 0 && q_beat[$].cyc > c) void'(q_beat.pop_back());
        while (q_wr.size() > 0 && q_wr[$].cyc > c) void'(q_wr.pop_back());
        while (q_done.size() > 0 && q_done[$].cyc > c) void'(q_done.pop_back());
        while (q_bias.size() > 0 && q_bias[$].cyc > c) void'(q_bias.pop_back());
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_pulse(output int s);
        @(posedge clk);
        #1;
        s = cyc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (acc_clr === 1'b1) begin
                if (q_clr.size() == 0) chk("clr_unexpected", 32'(acc_clr), 32'd0);
                else begin
                    me = q_clr.pop_front();
                    chk("clr_cycle", cyc, me.cyc);
                    chk("clr_in_idx", 32'(in_idx), 32'd0);
                    chk("clr_out_idx", 32'(out_idx), me.val);
                end
            end
            if (acc_en === 1'b1) begin
                if (q_beat.size() == 0) chk("beat_unexpected", 32'(acc_en), 32'd0);
                else begin
                    me = q_beat.pop_front();
                    chk("beat_cycle", cyc, me.cyc);
                    chk("beat_w_addr", 32'(w_addr), me.val);
                    chk("beat_in_idx", 32'(in_idx), me.val % NI);
                    chk("beat_out_idx", 32'(out_idx), me.val / NI);
                end
            end
`ifdef NN_LAYER_SEQ_BIAS_EN
            if (bias_en === 1'b1) begin
                if (q_bias.size() == 0) chk("bias_unexpected", 32'(bias_en), 32'd0);
                else begin
                    me = q_bias.pop_front();
                    chk("bias_cycle", cyc, me.cyc);
                end
            end
`endif
            if (out_wr === 1'b1) begin
                if (q_wr.size() == 0) chk("wr_unexpected", 32'(out_wr), 32'd0);
                else begin
                    me = q_wr.pop_front();
                    chk("wr_cycle", cyc, me.cyc);
                    chk("wr_out_idx", 32'(out_idx), me.val);
                end
            end
            if (done === 1'b1) begin
                if (q_done.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
                else begin
                    me = q_done.pop_front();
                    chk("done_cycle", cyc, me.cyc);
                    chk("done_busy", 32'(busy), 32'd1);
                end
            end
        end
    end

    initial begin
        int s;
        int s2;
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_outputs", 32'({state, busy, done, acc_clr, acc_en, out_wr, in_idx, out_idx, w_addr}), 32'd0);
`ifdef NN_LAYER_SEQ_BIAS_EN
            chk("idle_bias_en", 32'(bias_en), 32'd0);
`endif
        end
        mon_en = 1'b1;

        // Full layer, no stall
        start_pulse(s);
        push_layer(s, -1, 0);
        wait_cyc(s + NO * P + 2);
        @(negedge clk);
        chk("layer_busy_after", 32'(busy), 32'd0);
        chk("layer_state_after", 32'(state), 32'd0);

        // Stall for 3 cycles at in_idx 5 of neuron 0, plus a stray stall in WRITE
        start_pulse(s);
        push_layer(s, 5, 3);
        wait_cyc(s + 7);
        stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_idx", 32'(in_idx), 32'd5);
            chk("stall_w_addr", 32'(w_addr), 32'd5);
            chk("stall_acc_en", 32'(acc_en), 32'd0);
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        wait_cyc(s + 2 * P + 3);
        stall = 1'b1;
        @(negedge clk);
        chk("stall_in_write_state", 32'(state), 32'd4);
        @(posedge clk);
        #1;
        stall = 1'b0;
        wait_cyc(s + NO * P + 2 + 3);
        @(negedge clk);
        chk("stall_busy_after", 32'(busy), 32'd0);

        // Reset mid-layer
        start_pulse(s);
        push_layer(s, -1, 0);
        wait_cyc(s + 30);
        rst = 1'b1;
        drop_after(s + 30);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_out_idx", 32'(out_idx), 32'd0);
        chk("rst_in_idx", 32'(in_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        wait_cyc(s + 110);

        // Start while busy is dropped; start during DONE dropped; start in IDLE accepted
        start_pulse(s);
        push_layer(s, -1, 0);
        wait_cyc(s + 40);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cyc(s + NO * P + 1);
        start = 1'b1;
        s2 = s + NO * P + 2;
        push_layer(s2, -1, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_cyc(s2 + NO * P + 2);
        @(negedge clk);
        chk("restart_busy_after", 32'(busy), 32'd0);

        chk("left_clr", q_clr.size(), 0);
        chk("left_beat", q_beat.size(), 0);
        chk("left_wr", q_wr.size(), 0);
        chk("left_done", q_done.size(), 0);
        chk("left_bias", q_bias.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_layer_seq.md
# nn_layer_seq

Sequencer for one fully-connected layer of the neural-net datapath. It drives the shared MAC accumulator through clear / accumulate / write-back for each output neuron in turn. It generates input-activation indices and weight-memory addresses, and reports completion to the top-level controller. It sits between the top-level start/done control and the accumulator, weight ROM and activation buffers.

## Interface
Parameters:
- N_IN, 16, inputs per neuron (power of two, ≥2)
- N_OUT, 4, output neurons per layer (power of two, ≥1)
- IN_W, $clog2(N_IN), input index width
- OUT_W, max(1,$clog2(N_OUT)), output index width

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin layer; sampled only in IDLE
- stall  in  1  upstream data not ready; freezes ACCUM
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on layer completion
- state  out  3  current FSM state encoding, for debug
- acc_clr  out  1  clear accumulator
- acc_en  out  1  accumulate current product
- in_idx  out  IN_W  activation index
- w_addr  out  IN_W+OUT_W  weight address = {out_idx, in_idx}
- out_idx  out  OUT_W  neuron being computed
- out_wr  out  1  write accumulator result to out_idx

## Operation
- State encoding: IDLE=0, CLEAR=1, ACCUM=2, BIAS=3, WRITE=4, DONE=5. All outputs are registered Moore decodes of state and counters.
- Transitions:
  - IDLE→CLEAR on start=1; IDLE otherwise.
  - CLEAR→ACCUM.
  - ACCUM holds while stall=1. Otherwise it increments in_idx. When in_idx==N_IN-1 and stall=0, it goes to BIAS (if enabled), else WRITE.
  - BIAS→WRITE.
  - WRITE→DONE if out_idx==N_OUT-1, else CLEAR with out_idx+1.
  - DONE→IDLE.
- Per-state outputs:
  - CLEAR: acc_clr=1, in_idx=0.
  - ACCUM: acc_en=~stall; in_idx and w_addr valid for the current cycle.
  - WRITE: out_wr=1.
  - DONE: done=1.
- Counters:
  - in_idx wraps N_IN-1→0 at the ACCUM exit.
  - out_idx resets to 0 on entry to CLEAR from IDLE. It is held through DONE and cleared in IDLE.
- start while busy=1 is ignored and not queued.
- stall outside ACCUM has no effect.

## Timing
- Reset values: state=IDLE, busy=0, done=0, acc_clr=0, acc_en=0, out_wr=0, in_idx=0, out_idx=0, w_addr=0.
- start accepted at edge k gives CLEAR in cycle k+1 and ACCUM in cycles k+2..k+1+N_IN, with no stall.
- Cycles per neuron = N_IN+2, or N_IN+3 with bias.
- With defaults and no stall, done is high in cycle k+1+4·18 = k+73.
- Each stall cycle extends the layer by exactly one cycle. in_idx and w_addr hold during a stall.
- rst=1 in any state forces reset values at the next edge. rst has priority over start and stall. No partial out_wr or done is issued after rst.
- done and start in the same cycle: start is ignored because the FSM is not in IDLE. A new start is accepted one cycle after DONE.

## Configuration
- NN_LAYER_SEQ_BIAS_EN defined:
  - BIAS state is present.
  - Output port bias_en (1 bit) is high for one cycle between the last ACCUM and WRITE.
- NN_LAYER_SEQ_BIAS_EN undefined:
  - BIAS state and bias_en port are absent.
  - ACCUM goes straight to WRITE.
  - Encoding 3 is unused.

## Structure
- Shared package nn_seq_pkg holds:
  - state enum and encodings
  - default N_IN/N_OUT constants
  - w_addr packing rule
- One sub-module, nn_idx_cnt: a wrapping counter with clear, enable and terminal-count outputs. It is instantiated twice, for in_idx and out_idx.
- FSM and output decode live in nn_layer_seq.

## Test plan
- Reset then idle: rst for 2 cycles, no start → all outputs 0 and state=0 for 20 cycles.
- Full layer, defaults, no stall: start pulse at cycle 0 →
  - acc_clr at cycle 1
  - acc_en for cycles 2–17 with in_idx 0..15, w_addr 0..15
  - out_wr at cycle 18 with out_idx=0
  - w_addr 48..63 for neuron 3
  - done at cycle 73
  - busy=0 at cycle 74
- Stall: stall=1 for 3 cycles while in_idx=5 → in_idx holds at 5, acc_en=0 during stall, done delayed to cycle 76.
- Reset mid-layer: rst at cycle 30 (neuron 1, ACCUM) → next cycle state=IDLE, out_idx=0, no out_wr or done afterwards.
- Start while busy: second start at cycle 40 → ignored, done once at 73. Start at cycle 74 is accepted, acc_clr at 75.
- With NN_LAYER_SEQ_BIAS_EN: same stimulus as the full layer → bias_en at cycle 18, out_wr at 19, done at cycle 77.
